// File: rtl/noc_qos_output_arbiter.sv
// QoS output-port arbiter: highest QoS wins, ties round-robin, winner registered into a one-entry output stage.
// Optional starvation guard (urgent inputs bypass QoS) is enabled by defining NOC_QOS_ARB_STARVE_GUARD_EN.
module noc_qos_output_arbiter #(
    parameter int NumInputs       = 4,
    parameter int FlitWidth       = 64,
    parameter int QoS_Value_Width = 4,
    parameter int AgeWidth        = 6,
    parameter int AgeThreshold    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NumInputs-1:0]                 req_v_i,
    input  logic [NumInputs*QoS_Value_Width-1:0] req_qos_i,
    input  logic [NumInputs*FlitWidth-1:0]       req_flit_i,
    output logic [NumInputs-1:0]                 req_rdy_o,
    output logic                                 out_v_o,
    output logic [FlitWidth-1:0]                 out_flit_o,
    output logic [$clog2(NumInputs)-1:0]         out_src_o,
    input  logic                                 out_rdy_i
);

    localparam int SrcW = $clog2(NumInputs);
    localparam int QW   = QoS_Value_Width;

    typedef enum logic {EMPTY, FULL} stage_e;

    stage_e              state_q;
    logic [FlitWidth-1:0] flit_q;
    logic [SrcW-1:0]     src_q;
    logic [SrcW-1:0]     rr_ptr_q;

    logic                slot_free;
    logic                accept;
    logic                found;
    logic                use_qos;
    logic [NumInputs-1:0] cand;
    logic [QW-1:0]       best_qos;
    logic [SrcW-1:0]     win_idx;
    logic [SrcW-1:0]     idx;
    logic [SrcW-1:0]     rr_next;

    function automatic logic [SrcW-1:0] rr_index(input logic [SrcW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NumInputs) sum -= NumInputs;
        return SrcW'(sum);
    endfunction

`ifdef NOC_QOS_ARB_STARVE_GUARD_EN
    logic [AgeWidth-1:0]  age_q [NumInputs];
    logic [AgeWidth-1:0]  age_d [NumInputs];
    logic [NumInputs-1:0] urgent;

    always_comb begin
        for (int i = 0; i < NumInputs; i++) begin
            urgent[i] = (int'(age_q[i]) >= AgeThreshold);
        end
    end
`else
    logic unused_age_cfg;
    assign unused_age_cfg = (AgeWidth > 0) ^ (AgeThreshold > 0);
`endif

    assign slot_free = (state_q == EMPTY) || out_rdy_i;

    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        cand     = req_v_i;
        use_qos  = 1'b1;
`ifdef NOC_QOS_ARB_STARVE_GUARD_EN
        if (|(req_v_i & urgent)) begin
            cand    = req_v_i & urgent;
            use_qos = 1'b0;
        end
`endif
        found    = 1'b0;
        best_qos = '0;
        win_idx  = '0;
        idx      = '0;
        // Scan from rr_ptr upward; only a strictly higher QoS displaces the earlier find, so ties stay round-robin.
        for (int k = 0; k < NumInputs; k++) begin
            idx = rr_index(rr_ptr_q, k);
            if (cand[idx] && (!found || (use_qos && (req_qos_i[idx*QW +: QW] > best_qos)))) begin
                found    = 1'b1;
                best_qos = req_qos_i[idx*QW +: QW];
                win_idx  = idx;
            end
        end
    end

    // Gating with rst_n keeps req_rdy_o low during reset even while requesters hold valid.
    assign accept  = rst_n && slot_free && found;
    assign rr_next = (win_idx == SrcW'(NumInputs - 1)) ? '0 : win_idx + SrcW'(1);

    always_comb begin
        req_rdy_o          = '0;
        req_rdy_o[win_idx] = accept;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            flit_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else if (slot_free) begin
            if (accept) begin
                state_q  <= FULL;
                flit_q   <= req_flit_i[win_idx*FlitWidth +: FlitWidth];
                src_q    <= win_idx;
                rr_ptr_q <= rr_next;
            end else begin
                state_q  <= EMPTY;
            end
        end
    end

`ifdef NOC_QOS_ARB_STARVE_GUARD_EN
    always_comb begin
        for (int i = 0; i < NumInputs; i++) begin
            if (!req_v_i[i] || req_rdy_o[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != '1) begin
                age_d[i] = age_q[i] + AgeWidth'(1);
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    // NOTE: the age array is control state, so it is reset like any other flop rather than left as uninitialised storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumInputs; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumInputs; i++) age_q[i] <= age_d[i];
        end
    end
`endif

    assign out_v_o    = (state_q == FULL);
    assign out_flit_o = flit_q;
    assign out_src_o  = src_q;

endmodule

// File: tb/tb_noc_qos_output_arbiter.sv
// Scoreboard bench for noc_qos_output_arbiter: a reference model predicts each accept, the output side pops and compares.
module tb_noc_qos_output_arbiter;

    localparam int N  = 4;
    localparam int FW = 64;
    localparam int QW = 4;
    localparam int AW = 6;
    localparam int AT = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_v;
    logic [N*QW-1:0]  req_qos;
    logic [N*FW-1:0]  req_flit;
    logic [N-1:0]     req_rdy;
    logic             out_v;
    logic [FW-1:0]    out_flit;
    logic [1:0]       out_src;
    logic             out_rdy;

    logic [QW-1:0]    qos_a  [N];
    logic [FW-1:0]    flit_a [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_qos[g*QW +: QW]  = qos_a[g];
        assign req_flit[g*FW +: FW] = flit_a[g];
    end

    always #5 clk = ~clk;

    noc_qos_output_arbiter #(
        .NumInputs(N), .FlitWidth(FW), .QoS_Value_Width(QW), .AgeWidth(AW), .AgeThreshold(AT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_v_i(req_v), .req_qos_i(req_qos), .req_flit_i(req_flit),
        .req_rdy_o(req_rdy), .out_v_o(out_v), .out_flit_o(out_flit), .out_src_o(out_src),
        .out_rdy_i(out_rdy)
    );

    typedef struct packed {
        logic [1:0]    src;
        logic [FW-1:0] flit;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;
    int   last_grant;
    bit   m_full;
    int   m_rr;
    int   m_age [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_winner();
        logic [N-1:0] cand;
        bit           use_q;
        int           maxq;
        cand  = req_v;
        use_q = 1'b1;
        maxq  = -1;
`ifdef NOC_QOS_ARB_STARVE_GUARD_EN
        begin
            logic [N-1:0] urg;
            for (int i = 0; i < N; i++) urg[i] = (m_age[i] >= AT);
            if (|(cand & urg)) begin
                cand  = cand & urg;
                use_q = 1'b0;
            end
        end
`endif
        for (int i = 0; i < N; i++) begin
            if (cand[i] && int'(qos_a[i]) > maxq) maxq = int'(qos_a[i]);
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (cand[j] && (!use_q || int'(qos_a[j]) == maxq)) return j;
        end
        return -1;
    endfunction

    task automatic new_flits();
        n_cyc++;
        for (int i = 0; i < N; i++) flit_a[i] = {32'(i) | 32'hF1170000, 32'(n_cyc)};
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        exp_t         e;
        int           w;
        bit           sf;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        check("out_v", out_v, m_full);
        sf = !m_full || out_rdy;
        if (m_full && out_rdy) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_src", out_src, e.src);
                check("out_flit", out_flit, e.flit);
            end
        end
        w = sf ? model_winner() : -1;
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_rdy", req_rdy, exp_rdy);
        last_grant = w;
        if (w >= 0) begin
            sb.push_back('{src: 2'(w), flit: flit_a[w]});
            m_rr = (w + 1) % N;
        end
        if (sf) m_full = (w >= 0);
        for (int i = 0; i < N; i++) begin
            if (!req_v[i] || w == i) m_age[i] = 0;
            else if (m_age[i] < (1 << AW) - 1) m_age[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m_full = 1'b0;
        m_rr   = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        sb.delete();
        #3;
        check("rst_out_v", out_v, 0);
        check("rst_req_rdy", req_rdy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [FW-1:0] held;
        int            first3;
        rst_n   = 1'b0;
        out_rdy = 1'b1;
        req_v   = '1;
        qos_a   = '{4'd3, 4'd7, 4'd7, 4'd1};
        new_flits();

        // Reset with all inputs valid, then tie between inputs 1 and 2 at QoS 7 goes to 1.
        do_reset();
        cycle();
        check("t1_grant", last_grant, 1);
        check("t1_src", out_src, 1);
        req_v = '0;
        cycle();

        // Equal QoS, continuously valid: pure round-robin at one flit per cycle.
        do_reset();
        req_v = '1;
        qos_a = '{4'd5, 4'd5, 4'd5, 4'd5};
        for (int k = 0; k < 5; k++) begin
            new_flits();
            cycle();
            check("t2_grant", last_grant, k % N);
            check("t2_out_v", out_v, 1);
        end

        // Downstream stall: output held, nothing accepted, pointer frozen.
        out_rdy = 1'b0;
        held    = out_flit;
        for (int k = 0; k < 5; k++) begin
            new_flits();
            cycle();
            check("t3_hold_flit", out_flit, held);
            check("t3_no_grant", last_grant, -1);
        end
        out_rdy = 1'b1;
        new_flits();
        cycle();
        check("t3_resume_grant", last_grant, 1);
        check("t3_new_flit", out_flit, flit_a[1]);

        // Single-cycle pulse on input 2, then the stage drains empty.
        req_v = '0;
        cycle();
        req_v     = 4'b0100;
        flit_a[2] = 64'hA5;
        cycle();
        check("t4_flit", out_flit, 64'hA5);
        check("t4_src", out_src, 2);
        req_v = '0;
        cycle();
        check("t4_empty", out_v, 0);

        // Asynchronous reset while full clears the output without a clock edge.
        req_v = '1;
        new_flits();
        cycle();
        check("t5_full", out_v, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_clear", out_v, 0);
        do_reset();
        new_flits();
        cycle();
        check("t5_rr_cleared", last_grant, 0);

        // High-QoS hog on input 0 against QoS-0 input 3.
        do_reset();
        req_v    = 4'b1001;
        qos_a[0] = 4'd15;
        qos_a[3] = 4'd0;
        first3   = -1;
        for (int c = 1; c <= 40; c++) begin
            new_flits();
            cycle();
            if (last_grant == 3 && first3 < 0) first3 = c;
        end
`ifdef NOC_QOS_ARB_STARVE_GUARD_EN
        check("t6_starve_grant_cycle", first3, 33);
`else
        check("t6_never_granted", first3, -1);
`endif

        // Random traffic with narrow QoS range to exercise ties and back-pressure.
        for (int c = 0; c < 300; c++) begin
            req_v   = 4'($urandom_range(0, 15));
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) qos_a[i] = 4'($urandom_range(0, 3));
            new_flits();
            cycle();
        end

        req_v   = '0;
        out_rdy = 1'b1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) cycle();
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
